fir_mac_param: RTL and testbench
================================

Name: fir_mac_param

Overview:
- Parametrised next-generation FIR engine with runtime-selectable tap count (1..pMAX_TAPS) and a single shared multiply-accumulate datapath.
- Coefficients and sample history are held in internal register arrays; the block has no external BRAM ports.
- Configured and controlled over AXI-Lite. Samples enter on AXI-Stream slave, results leave on AXI-Stream master with full backpressure.
- Sits between the host configuration bus and the stream fabric, as a drop-in successor to the fixed 11-tap engine.

Parameters:
- pADDR_WIDTH, 12, AXI-Lite address width
- pDATA_WIDTH, 32, sample/coefficient/result width (signed)
- pMAX_TAPS, 32, maximum taps; coefficient and history array depth
- pLEN_WIDTH, 16, data_length register width

Ports:
- axis_clk  in  1  the only clock
- axis_rst_n  in  1  asynchronous active-low reset
- awvalid/awready  in/out  1  write address handshake
- awaddr  in  pADDR_WIDTH  write address
- wvalid/wready  in/out  1  write data handshake
- wdata  in  pDATA_WIDTH  write data
- arvalid/arready  in/out  1  read address handshake
- araddr  in  pADDR_WIDTH  read address
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- rdata  out  pDATA_WIDTH  read data
- ss_tvalid/ss_tready  in/out  1  input stream handshake
- ss_tdata  in  pDATA_WIDTH  x[n]
- ss_tlast  in  1  informational only; ignored
- sm_tvalid/sm_tready  out/in  1  output stream handshake
- sm_tdata  out  pDATA_WIDTH  y[n]
- sm_tlast  out  1  last output of the run

Behaviour:
- Reset: all ready/valid outputs, sm_tdata, sm_tlast and rdata are 0. ap_idle=1, ap_done=0, tap_num=1, data_length=0. Coefficients and history are 0. FSM is IDLE. Asserting reset mid-run aborts immediately to this state.
- Register map:
  - 0x00: bit0 ap_start (write 1, self-clearing), bit1 ap_done (cleared by a read of 0x00), bit2 ap_idle.
  - 0x10: data_length.
  - 0x14: tap_num; written values are clamped to 1..pMAX_TAPS.
  - 0x80+4i: coefficient i.
  - Unmapped reads return 0.
- AXI-Lite write:
  - awready=wready=1 for exactly one cycle, only when awvalid&wvalid are both high. Address and data are accepted together.
  - Writes to 0x10, 0x14 and coefficients while ap_idle=0 are ignored.
  - No B channel.
- AXI-Lite read:
  - arready=1 while no read is outstanding.
  - rvalid rises the cycle after the ar handshake and holds with stable rdata until rready.
  - Coefficient reads are legal at any time.
- ap_start:
  - Honoured only when ap_idle=1 and data_length!=0.
  - That cycle: clear ap_done and ap_idle, zero all history entries, zero the output counter, go to WAIT_X.
- FSM states:
  - IDLE -> WAIT_X: on accepted ap_start.
  - WAIT_X: ss_tready=1. On ss handshake, write x into history at head, advance head (wrap at pMAX_TAPS), clear acc, i=0, go to MAC.
  - MAC: one product per cycle, acc += h[i]*x[(head_new-1-i) mod pMAX_TAPS], for i=0..tap_num-1. Then go to OUT.
  - OUT: sm_tvalid=1, sm_tdata=acc, held stable until sm_tready. On handshake, increment count. If count==data_length, go to IDLE and set ap_done=1 and ap_idle=1 in the same cycle; else go to WAIT_X.
- ss_tready=0 in every state except WAIT_X.
- Latency: ss handshake at cycle T gives sm_tvalid=1 at T+tap_num+1. Throughput is one sample per tap_num+2 cycles with sm_tready tied high.
- sm_tlast=1 together with sm_tvalid only on output number data_length.
- Arithmetic: signed operands. The product is truncated to the low pDATA_WIDTH bits; accumulation wraps modulo 2^pDATA_WIDTH with no saturation.
- History is not cleared between samples. Entries not yet written in the current run read 0.
- Simultaneous AXI-Lite read of 0x00 and ap_done set in the same cycle: the read returns the old value, and ap_done stays set.

Test Plan:
- tap_num=3, h={1,2,3}, data_length=4, x=1,2,3,4, sm_tready=1 -> y=1,4,10,16; sm_tlast on 16; ap_done=1, ap_idle=1; a second read of 0x00 shows ap_done=0.
- Same config run twice back-to-back -> second run again yields 1,4,10,16, proving history is cleared on ap_start.
- sm_tready held low 5 cycles during OUT -> sm_tdata stable, ss_tready=0 throughout, no sample lost.
- tap_num=pMAX_TAPS, all h=1, data_length=40, x=1 each -> y ramps 1..32 then holds 32, confirming wrap of head.
- Write coefficient 0x80 and 0x14 while busy -> readback unchanged; then write 0x14=0 -> reads back 1, and write 0x14=100 -> reads back pMAX_TAPS.
- Assert axis_rst_n low during MAC -> sm_tvalid=0 immediately; ap_idle=1, coefficients=0, tap_num=1 after release.

Source files
------------

// File: rtl/fir_mac_param_if.sv
// AXI-Lite control and AXI-Stream data bundle for the parametrised FIR MAC engine.
// slave is the engine's view, master is the host/fabric view.
interface fir_mac_param_if #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
);
    logic                   awvalid;
    logic                   awready;
    logic [pADDR_WIDTH-1:0] awaddr;
    logic                   wvalid;
    logic                   wready;
    logic [pDATA_WIDTH-1:0] wdata;
    logic                   arvalid;
    logic                   arready;
    logic [pADDR_WIDTH-1:0] araddr;
    logic                   rvalid;
    logic                   rready;
    logic [pDATA_WIDTH-1:0] rdata;
    logic                   ss_tvalid;
    logic                   ss_tready;
    logic [pDATA_WIDTH-1:0] ss_tdata;
    logic                   ss_tlast;
    logic                   sm_tvalid;
    logic                   sm_tready;
    logic [pDATA_WIDTH-1:0] sm_tdata;
    logic                   sm_tlast;

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
               ss_tvalid, ss_tdata, ss_tlast, sm_tready,
        output awready, wready, arready, rvalid, rdata,
               ss_tready, sm_tvalid, sm_tdata, sm_tlast
    );

    modport master (
        output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
               ss_tvalid, ss_tdata, ss_tlast, sm_tready,
        input  awready, wready, arready, rvalid, rdata,
               ss_tready, sm_tvalid, sm_tdata, sm_tlast
    );
endinterface

// File: rtl/fir_mac_param.sv
// FIR engine with runtime tap count and one shared multiply-accumulate unit.
// Coefficients and sample history live in register arrays; control over AXI-Lite.
module fir_mac_param #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pMAX_TAPS   = 32,
    parameter int pLEN_WIDTH  = 16
) (
    input logic             axis_clk,
    input logic             axis_rst_n,
    fir_mac_param_if.slave  bus
);
    localparam int IW = $clog2(pMAX_TAPS);
    localparam int TW = $clog2(pMAX_TAPS + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT_X = 2'd1;
    localparam logic [1:0] S_MAC    = 2'd2;
    localparam logic [1:0] S_OUT    = 2'd3;

    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = pADDR_WIDTH'('h00);
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'('h10);
    localparam logic [pADDR_WIDTH-1:0] ADDR_TAPS = pADDR_WIDTH'('h14);
    localparam logic [pADDR_WIDTH-1:0] COEF_BASE = pADDR_WIDTH'('h80);
    localparam logic [pADDR_WIDTH-1:0] COEF_END  = pADDR_WIDTH'('h80 + 4 * pMAX_TAPS);

    logic [1:0]             state;
    logic                   w_ack;
    logic                   live;
    logic                   rvalid_q;
    logic [pDATA_WIDTH-1:0] rdata_q;
    logic                   ap_done;
    logic                   ap_idle;
    logic [pLEN_WIDTH-1:0]  data_length;
    logic [pLEN_WIDTH-1:0]  out_cnt;
    logic [TW-1:0]          tap_num;
    logic [pDATA_WIDTH-1:0] coef [pMAX_TAPS];
    logic [pDATA_WIDTH-1:0] hist [pMAX_TAPS];
    logic [IW-1:0]          head;
    logic [IW-1:0]          rd_ptr;
    logic [IW-1:0]          tap_idx;
    logic [pDATA_WIDTH-1:0] acc;

    logic                     wr_fire;
    logic                     cfg_wr;
    logic                     start_fire;
    logic                     rd_fire;
    logic                     rd_ctrl;
    logic                     w_coef;
    logic                     r_coef;
    logic [pADDR_WIDTH-1:0]   w_off;
    logic [pADDR_WIDTH-1:0]   r_off;
    logic [TW-1:0]            tap_wr;
    logic [pDATA_WIDTH-1:0]   rd_val;
    logic signed [2*pDATA_WIDTH-1:0] prod;
    logic                     tap_last;
    logic [pLEN_WIDTH-1:0]    cnt_inc;
    logic                     unused_bits;

    assign wr_fire    = w_ack & bus.awvalid & bus.wvalid;
    assign cfg_wr     = wr_fire & ap_idle;
    assign start_fire = wr_fire && (bus.awaddr == ADDR_CTRL) && bus.wdata[0]
                        && ap_idle && (data_length != '0);
    assign rd_fire    = bus.arvalid & live & ~rvalid_q;
    assign rd_ctrl    = rd_fire && (bus.araddr == ADDR_CTRL);

    assign w_off  = bus.awaddr - COEF_BASE;
    assign r_off  = bus.araddr - COEF_BASE;
    assign w_coef = (bus.awaddr >= COEF_BASE) && (bus.awaddr < COEF_END) && (bus.awaddr[1:0] == 2'b00);
    assign r_coef = (bus.araddr >= COEF_BASE) && (bus.araddr < COEF_END) && (bus.araddr[1:0] == 2'b00);

    assign prod     = $signed(coef[tap_idx]) * $signed(hist[rd_ptr]);
    assign tap_last = (TW'(tap_idx) == tap_num - TW'(1));
    assign cnt_inc  = out_cnt + pLEN_WIDTH'(1);

    assign unused_bits = ^{bus.ss_tlast, prod[2*pDATA_WIDTH-1:pDATA_WIDTH], w_off, r_off};

    always_comb begin
        tap_wr = bus.wdata[TW-1:0];
        if (bus.wdata == '0)
            tap_wr = TW'(1);
        else if (bus.wdata > pDATA_WIDTH'(pMAX_TAPS))
            tap_wr = TW'(pMAX_TAPS);
    end

    always_comb begin
        rd_val = '0;
        if (bus.araddr == ADDR_CTRL)
            rd_val[2:0] = {ap_idle, ap_done, 1'b0};
        else if (bus.araddr == ADDR_LEN)
            rd_val[pLEN_WIDTH-1:0] = data_length;
        else if (bus.araddr == ADDR_TAPS)
            rd_val[TW-1:0] = tap_num;
        else if (r_coef)
            rd_val = coef[r_off[IW+1:2]];
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state       <= S_IDLE;
            w_ack       <= 1'b0;
            live        <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            ap_done     <= 1'b0;
            ap_idle     <= 1'b1;
            data_length <= '0;
            out_cnt     <= '0;
            tap_num     <= TW'(1);
            head        <= '0;
            rd_ptr      <= '0;
            tap_idx     <= '0;
            acc         <= '0;
            for (int unsigned k = 0; k < pMAX_TAPS; k++) begin
                coef[k] <= '0;
                hist[k] <= '0;
            end
        end else begin
            live  <= 1'b1;
            w_ack <= bus.awvalid & bus.wvalid & ~w_ack;

            if (rd_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_val;
            end else if (rvalid_q && bus.rready) begin
                rvalid_q <= 1'b0;
            end

            if (cfg_wr) begin
                if (bus.awaddr == ADDR_LEN)
                    data_length <= bus.wdata[pLEN_WIDTH-1:0];
                else if (bus.awaddr == ADDR_TAPS)
                    tap_num <= tap_wr;
                else if (w_coef)
                    coef[w_off[IW+1:2]] <= bus.wdata;
            end

            // A status read clears ap_done, but a completion in the same cycle wins below.
            if (rd_ctrl)
                ap_done <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start_fire) begin
                        ap_done <= 1'b0;
                        ap_idle <= 1'b0;
                        out_cnt <= '0;
                        head    <= '0;
                        for (int unsigned k = 0; k < pMAX_TAPS; k++)
                            hist[k] <= '0;
                        state <= S_WAIT_X;
                    end
                end
                S_WAIT_X: begin
                    if (bus.ss_tvalid) begin
                        hist[head] <= bus.ss_tdata;
                        rd_ptr     <= head;
                        head       <= (head == IW'(pMAX_TAPS - 1)) ? '0 : head + IW'(1);
                        acc        <= '0;
                        tap_idx    <= '0;
                        state      <= S_MAC;
                    end
                end
                S_MAC: begin
                    // Walk backwards from the newest sample; low product bits are sign-agnostic.
                    acc     <= acc + prod[pDATA_WIDTH-1:0];
                    rd_ptr  <= (rd_ptr == '0) ? IW'(pMAX_TAPS - 1) : rd_ptr - IW'(1);
                    tap_idx <= tap_idx + IW'(1);
                    if (tap_last)
                        state <= S_OUT;
                end
                default: begin
                    if (bus.sm_tready) begin
                        out_cnt <= cnt_inc;
                        if (cnt_inc == data_length) begin
                            ap_done <= 1'b1;
                            ap_idle <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            state <= S_WAIT_X;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.awready   = w_ack;
    assign bus.wready    = w_ack;
    assign bus.arready   = live & ~rvalid_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.rdata     = rdata_q;
    assign bus.ss_tready = (state == S_WAIT_X);
    assign bus.sm_tvalid = (state == S_OUT);
    assign bus.sm_tdata  = acc;
    assign bus.sm_tlast  = (state == S_OUT) && (cnt_inc == data_length);
endmodule

// File: tb/tb_fir_mac_param.sv
// Scoreboard bench for fir_mac_param: a direct-convolution model feeds an expected
// queue, and an independent monitor compares every accepted output beat.
module tb_fir_mac_param;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int MT = 32;
    localparam int LW = 16;

    logic axis_clk   = 1'b0;
    logic axis_rst_n = 1'b0;
    always #5 axis_clk = ~axis_clk;

    fir_mac_param_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) bus ();

    fir_mac_param #(
        .pADDR_WIDTH(AW),
        .pDATA_WIDTH(DW),
        .pMAX_TAPS  (MT),
        .pLEN_WIDTH (LW)
    ) dut (
        .axis_clk  (axis_clk),
        .axis_rst_n(axis_rst_n),
        .bus       (bus)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    int            tests = 0;
    int            fails = 0;
    exp_t          exp_q[$];
    exp_t          e;
    logic [DW-1:0] h_arr[MT];
    logic [DW-1:0] xs[$];
    int            sink_mode = 0;
    int            hold = 0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] stall_data = '0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Output sink: 0 = always ready, 1 = random, 2 = hold ready low 5 cycles per output.
    always @(posedge axis_clk) begin
        #1;
        case (sink_mode)
            0: bus.sm_tready = 1'b1;
            1: bus.sm_tready = 1'($urandom_range(0, 1));
            default: begin
                if (bus.sm_tvalid && hold < 5) begin
                    bus.sm_tready = 1'b0;
                    hold++;
                end else begin
                    bus.sm_tready = 1'b1;
                    if (bus.sm_tvalid) hold = 0;
                end
            end
        endcase
    end

    always @(negedge axis_clk) begin
        if (!axis_rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (bus.sm_tvalid)
                check("ss_tready_low_during_out", DW'(bus.ss_tready), '0);
            if (stall_prev) begin
                check("sm_tvalid_held", DW'(bus.sm_tvalid), DW'(1));
                check("sm_tdata_stable", bus.sm_tdata, stall_data);
            end
            stall_prev = bus.sm_tvalid && !bus.sm_tready;
            stall_data = bus.sm_tdata;
            if (bus.sm_tvalid && bus.sm_tready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got %0h expected none", bus.sm_tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("sm_tdata", bus.sm_tdata, e.data);
                    check("sm_tlast", DW'(bus.sm_tlast), DW'(e.last));
                end
            end
        end
    end

    task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        bus.awaddr  = a;
        bus.wdata   = d;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        @(negedge axis_clk);
        while (!bus.awready && n < 100) begin
            @(negedge axis_clk);
            n++;
        end
        if (!bus.awready) begin
            tests++;
            fails++;
            $display("FAIL axi_write_timeout: got no awready expected awready for addr %0h", a);
        end
        @(posedge axis_clk);
        #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
        int n = 0;
        d = '0;
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        @(negedge axis_clk);
        while (!bus.arready && n < 100) begin
            @(negedge axis_clk);
            n++;
        end
        @(posedge axis_clk);
        #1;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;
        n = 0;
        @(negedge axis_clk);
        while (!bus.rvalid && n < 100) begin
            @(negedge axis_clk);
            n++;
        end
        if (!bus.rvalid) begin
            tests++;
            fails++;
            $display("FAIL axi_read_timeout: got no rvalid expected rvalid for addr %0h", a);
        end
        d = bus.rdata;
        @(posedge axis_clk);
        #1;
        bus.rready = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [AW-1:0] a, input logic [DW-1:0] expv);
        logic [DW-1:0] d;
        axi_read(a, d);
        check(name, d, expv);
    endtask

    task automatic configure(input int taps);
        axi_write(AW'('h14), DW'(taps));
        for (int i = 0; i < taps; i++)
            axi_write(AW'('h80 + 4 * i), h_arr[i]);
        axi_write(AW'('h10), DW'(xs.size()));
    endtask

    // y[n] = sum over i<taps of h[i]*x[n-i], earlier-than-run samples taken as zero.
    task automatic push_expected(input int taps);
        for (int n = 0; n < xs.size(); n++) begin
            logic [DW-1:0] y;
            exp_t t;
            y = '0;
            for (int i = 0; i < taps; i++) begin
                if (n - i >= 0) begin
                    logic signed [2*DW-1:0] p;
                    p = $signed(h_arr[i]) * $signed(xs[n - i]);
                    y = y + p[DW-1:0];
                end
            end
            t.data = y;
            t.last = (n == xs.size() - 1);
            exp_q.push_back(t);
        end
    endtask

    task automatic send_all(input bit gaps);
        for (int k = 0; k < xs.size(); k++) begin
            int n = 0;
            if (gaps) repeat ($urandom_range(0, 3)) @(posedge axis_clk);
            #1;
            bus.ss_tvalid = 1'b1;
            bus.ss_tdata  = xs[k];
            @(negedge axis_clk);
            while (!bus.ss_tready && n < 3000) begin
                @(negedge axis_clk);
                n++;
            end
            if (!bus.ss_tready) begin
                tests++;
                fails++;
                $display("FAIL ss_handshake_timeout: got no ss_tready expected ss_tready for sample %0d", k);
            end
            @(posedge axis_clk);
            #1;
            bus.ss_tvalid = 1'b0;
        end
    endtask

    task automatic finish_run();
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(negedge axis_clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d outputs missing expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge axis_clk);
        #1;
        read_check("status_done_idle", AW'('h00), DW'(6));
        read_check("status_done_cleared", AW'('h00), DW'(4));
    endtask

    task automatic full_run(input int taps, input bit gaps);
        configure(taps);
        push_expected(taps);
        axi_write(AW'('h00), DW'(1));
        send_all(gaps);
        finish_run();
    endtask

    task automatic set_basic();
        for (int i = 0; i < MT; i++) h_arr[i] = '0;
        h_arr[0] = 1; h_arr[1] = 2; h_arr[2] = 3;
        xs.delete();
        for (int i = 1; i <= 4; i++) xs.push_back(DW'(i));
    endtask

    task automatic reset_state_checks(input string tag);
        check({tag, "_sm_tvalid"}, DW'(bus.sm_tvalid), '0);
        check({tag, "_sm_tlast"},  DW'(bus.sm_tlast), '0);
        check({tag, "_ss_tready"}, DW'(bus.ss_tready), '0);
        check({tag, "_awready"},   DW'(bus.awready), '0);
        check({tag, "_wready"},    DW'(bus.wready), '0);
        check({tag, "_arready"},   DW'(bus.arready), '0);
        check({tag, "_rvalid"},    DW'(bus.rvalid), '0);
        check({tag, "_rdata"},     bus.rdata, '0);
        check({tag, "_sm_tdata"},  bus.sm_tdata, '0);
    endtask

    initial begin
        bus.awvalid = 0; bus.awaddr = '0; bus.wvalid = 0; bus.wdata = '0;
        bus.arvalid = 0; bus.araddr = '0; bus.rready = 0;
        bus.ss_tvalid = 0; bus.ss_tdata = '0; bus.ss_tlast = 0;
        bus.sm_tready = 1;

        // Reset values
        repeat (3) @(negedge axis_clk);
        reset_state_checks("reset");
        @(posedge axis_clk);
        #1;
        axis_rst_n = 1'b1;
        read_check("reset_status", AW'('h00), DW'(4));
        read_check("reset_tap_num", AW'('h14), DW'(1));
        read_check("reset_data_length", AW'('h10), '0);
        read_check("reset_coef0", AW'('h80), '0);
        read_check("unmapped_read", AW'('h40), '0);

        // ap_start is ignored while data_length is zero
        axi_write(AW'('h00), DW'(1));
        read_check("start_ignored_len0", AW'('h00), DW'(4));

        // Basic run, then the same again to confirm history is cleared on start
        sink_mode = 0;
        set_basic();
        full_run(3, 1'b0);
        full_run(3, 1'b0);

        // Output backpressure
        sink_mode = 2;
        full_run(3, 1'b0);
        sink_mode = 0;

        // Full tap count with 40 samples exercises head wrap
        for (int i = 0; i < MT; i++) h_arr[i] = DW'(1);
        xs.delete();
        for (int i = 0; i < 40; i++) xs.push_back(DW'(1));
        full_run(MT, 1'b0);

        // Config writes while busy are dropped
        set_basic();
        configure(3);
        push_expected(3);
        axi_write(AW'('h00), DW'(1));
        axi_write(AW'('h80), DW'(77));
        axi_write(AW'('h14), DW'(9));
        axi_write(AW'('h10), DW'(99));
        read_check("busy_status", AW'('h00), '0);
        read_check("busy_coef0_kept", AW'('h80), DW'(1));
        read_check("busy_tap_kept", AW'('h14), DW'(3));
        read_check("busy_len_kept", AW'('h10), DW'(4));
        send_all(1'b0);
        finish_run();

        // tap_num clamping
        axi_write(AW'('h14), DW'(0));
        read_check("tap_clamp_low", AW'('h14), DW'(1));
        axi_write(AW'('h14), DW'(100));
        read_check("tap_clamp_high", AW'('h14), DW'(MT));

        // Randomised runs with signed full-width values, random gaps and backpressure
        sink_mode = 1;
        for (int r = 0; r < 5; r++) begin
            int taps;
            int len;
            taps = (r == 0) ? 1 : $urandom_range(1, MT);
            len  = (r == 1) ? 1 : $urandom_range(1, 12);
            for (int i = 0; i < MT; i++) h_arr[i] = DW'($urandom);
            xs.delete();
            for (int i = 0; i < len; i++) xs.push_back(DW'($urandom));
            full_run(taps, 1'b1);
        end
        sink_mode = 0;

        // Reset asserted mid-MAC
        for (int i = 0; i < MT; i++) h_arr[i] = DW'('h55);
        xs.delete();
        xs.push_back(DW'(5));
        configure(MT);
        axi_write(AW'('h10), DW'(4));
        axi_write(AW'('h00), DW'(1));
        send_all(1'b0);
        repeat (3) @(posedge axis_clk);
        #1;
        axis_rst_n = 1'b0;
        #1;
        reset_state_checks("midrun_reset");
        @(posedge axis_clk);
        #1;
        axis_rst_n = 1'b1;
        read_check("after_reset_status", AW'('h00), DW'(4));
        read_check("after_reset_coef0", AW'('h80), '0);
        read_check("after_reset_tap_num", AW'('h14), DW'(1));
        repeat (5) @(posedge axis_clk);
        check("after_reset_no_pending", DW'(exp_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: got no completion expected $finish");
        $fatal(1, "timeout");
    end
endmodule
